// File: rtl/mem_arbiter.sv
// ----------------------------------------------------------------------------
// mem_arbiter
//   Shares one byte-serial memory controller between the instruction-fetch
//   port (IF) and the load/store port (LS). At most one transfer is in flight.
//   LS normally wins a simultaneous request. A starvation counter forces an
//   IF grant after STARVE_MAX back-to-back LS grants while IF was waiting.
//   A pipeline flush (jump_rst) drops fetches and loads that are in flight:
//   the controller is still allowed to finish, but no done pulse is given.
//   Stores already handed to the controller always complete and report done.
//
// Ports
//   clk, rst (async, active low), rdy (global enable / freeze)
//   jump_rst                   pipeline flush
//   if_req/if_addr             fetch request, if_done/if_data result
//   ls_req/ls_wr/ls_addr/
//   ls_size/ls_wdata           load/store request, ls_done/ls_rdata result
//   mc_valid/mc_type/mc_addr/
//   mc_size/mc_wdata           request to memory controller
//   mc_done/mc_rdata           controller completion
// ----------------------------------------------------------------------------
module mem_arbiter #(
   parameter int STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic        jump_rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_done,
   output logic [31:0] if_data,
   input  logic        ls_req,
   input  logic        ls_wr,
   input  logic [31:0] ls_addr,
   input  logic [2:0]  ls_size,
   input  logic [31:0] ls_wdata,
   output logic        ls_done,
   output logic [31:0] ls_rdata,
   output logic        mc_valid,
   output logic        mc_type,
   output logic [31:0] mc_addr,
   output logic [2:0]  mc_size,
   output logic [31:0] mc_wdata,
   input  logic        mc_done,
   input  logic [31:0] mc_rdata
);

   localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY_IF = 2'd1,
      BUSY_LS = 2'd2,
      DRAIN   = 2'd3
   } state_t;

   state_t             state_reg;
   logic [CNT_W-1:0]   starve_cnt_reg;

   logic               starved;
   logic               grant_if;
   logic               grant_ls;
   logic [2:0]         ls_size_fwd;
   logic [31:0]        load_masked;

   // IF only beats a pending LS once it has been passed over STARVE_MAX times.
   assign starved     = (starve_cnt_reg == CNT_MAX);
   assign grant_if    = if_req && (!ls_req || starved);
   assign grant_ls    = ls_req && !grant_if;

   // Unsupported access sizes are widened to a full word.
   assign ls_size_fwd = (ls_size == 3'd1 || ls_size == 3'd2 || ls_size == 3'd4) ?
                        ls_size : 3'd4;

   // Load data: keep only the byte lanes below the access size. mc_size is
   // always 1, 2 or 4 here, so lane gi survives when gi < mc_size.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         assign load_masked[8*gi +: 8] = (3'(gi) < mc_size) ? mc_rdata[8*gi +: 8] : 8'h00;
      end
   endgenerate

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg      <= IDLE;
         starve_cnt_reg <= '0;
         mc_valid       <= 1'b0;
         mc_type        <= 1'b0;
         mc_addr        <= '0;
         mc_size        <= '0;
         mc_wdata       <= '0;
         if_done        <= 1'b0;
         ls_done        <= 1'b0;
         if_data        <= '0;
         ls_rdata       <= '0;
      end else if (rdy) begin
         // Done outputs are single-cycle pulses unless frozen by rdy=0.
         if_done <= 1'b0;
         ls_done <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (jump_rst) begin
                  starve_cnt_reg <= '0;
               end else if (grant_if) begin
                  mc_valid       <= 1'b1;
                  mc_type        <= 1'b0;
                  mc_addr        <= if_addr;
                  mc_size        <= 3'd4;
                  mc_wdata       <= '0;
                  starve_cnt_reg <= '0;
                  state_reg      <= BUSY_IF;
               end else if (grant_ls) begin
                  mc_valid  <= 1'b1;
                  mc_type   <= ls_wr;
                  mc_addr   <= ls_addr;
                  mc_size   <= ls_size_fwd;
                  mc_wdata  <= ls_wdata;
                  state_reg <= BUSY_LS;
                  if (if_req && !starved)
                     starve_cnt_reg <= starve_cnt_reg + CNT_ONE;
               end
            end
            BUSY_IF: begin
               if (mc_done) begin
                  mc_valid  <= 1'b0;
                  state_reg <= IDLE;
                  if (!jump_rst) begin
                     if_done <= 1'b1;
                     if_data <= mc_rdata;
                  end
               end else if (jump_rst) begin
                  state_reg <= DRAIN;
               end
            end
            BUSY_LS: begin
               if (mc_done) begin
                  mc_valid  <= 1'b0;
                  state_reg <= IDLE;
                  // A flushed load is dropped; a store is committed regardless.
                  if (!jump_rst || mc_type) begin
                     ls_done  <= 1'b1;
                     ls_rdata <= mc_type ? 32'h0 : load_masked;
                  end
               end else if (jump_rst && !mc_type) begin
                  state_reg <= DRAIN;
               end
            end
            DRAIN: begin
               if (mc_done) begin
                  mc_valid  <= 1'b0;
                  state_reg <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_arbiter
//   Self-checking bench for mem_arbiter. The bench acts as both requesters
//   and as the memory controller. Directed scenarios cover fetch, priority,
//   starvation, flush, freeze and reset; a randomized run compares the DUT
//   against a transaction-level model of the arbitration rules.
// ----------------------------------------------------------------------------
module tb_mem_arbiter;

   localparam int STARVE_MAX = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        rdy;
   logic        jump_rst;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_done;
   logic [31:0] if_data;
   logic        ls_req;
   logic        ls_wr;
   logic [31:0] ls_addr;
   logic [2:0]  ls_size;
   logic [31:0] ls_wdata;
   logic        ls_done;
   logic [31:0] ls_rdata;
   logic        mc_valid;
   logic        mc_type;
   logic [31:0] mc_addr;
   logic [2:0]  mc_size;
   logic [31:0] mc_wdata;
   logic        mc_done;
   logic [31:0] mc_rdata;

   int checks = 0;
   int errors = 0;

   mem_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .jump_rst(jump_rst),
      .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
      .ls_req(ls_req), .ls_wr(ls_wr), .ls_addr(ls_addr), .ls_size(ls_size),
      .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata),
      .mc_valid(mc_valid), .mc_type(mc_type), .mc_addr(mc_addr),
      .mc_size(mc_size), .mc_wdata(mc_wdata), .mc_done(mc_done),
      .mc_rdata(mc_rdata)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // Inputs are driven and outputs sampled 1 time unit after each rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Contents of the pretend memory.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
   endfunction

   function automatic logic [31:0] load_expect(input logic [31:0] w, input logic [2:0] sz);
      if (sz == 3'd1) return w & 32'h0000_00FF;
      if (sz == 3'd2) return w & 32'h0000_FFFF;
      return w;
   endfunction

   function automatic logic [2:0] fwd_size(input logic [2:0] s);
      return (s == 3'd1 || s == 3'd2 || s == 3'd4) ? s : 3'd4;
   endfunction

   // Controller completes after lat extra cycles; returns just after done edge.
   task automatic serve(input int lat, input logic [31:0] data);
      repeat (lat) tick();
      mc_done  = 1'b1;
      mc_rdata = data;
      tick();
      mc_done  = 1'b0;
   endtask

   task automatic test_reset();
      logic [134:0] outs;
      if_req = 1'b1; if_addr = 32'h999;
      tick(); tick();
      outs = {mc_valid, mc_type, mc_addr, mc_size, mc_wdata, if_done, ls_done, if_data, ls_rdata};
      checks++; if (outs !== '0) begin errors++; $display("FAIL reset_outputs got=%h exp=0", outs); end
      if_req = 1'b0;
      rst = 1'b1;
      tick();
      checks++; if (mc_valid !== 1'b0) begin errors++; $display("FAIL reset_idle_valid got=%0b exp=0", mc_valid); end
   endtask

   task automatic test_fetch();
      if_addr = 32'h1000; if_req = 1'b1;
      tick();
      checks++; if ({mc_valid, mc_type, mc_size, mc_addr} !== {1'b1, 1'b0, 3'd4, 32'h1000}) begin
         errors++; $display("FAIL fetch_grant got=%0b/%0b/%0d/%h exp=1/0/4/00001000", mc_valid, mc_type, mc_size, mc_addr); end
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++; if ({mc_valid, mc_addr, mc_size} !== {1'b1, 32'h1000, 3'd4}) begin
            errors++; $display("FAIL fetch_hold got=%0b/%h/%0d exp=1/00001000/4", mc_valid, mc_addr, mc_size); end
      end
      mc_done = 1'b1; mc_rdata = 32'hDEAD_BEEF;
      tick();
      mc_done = 1'b0; if_req = 1'b0;
      checks++; if ({if_done, if_data, mc_valid} !== {1'b1, 32'hDEAD_BEEF, 1'b0}) begin
         errors++; $display("FAIL fetch_done got=%0b/%h/%0b exp=1/deadbeef/0", if_done, if_data, mc_valid); end
      $display("txn fetch addr=00001000 data=%h", if_data);
      tick();
      checks++; if (if_done !== 1'b0) begin errors++; $display("FAIL fetch_pulse_width got=%0b exp=0", if_done); end
   endtask

   task automatic test_priority();
      if_addr = 32'h1100; if_req = 1'b1;
      ls_wr = 1'b0; ls_size = 3'd1; ls_addr = 32'h20; ls_req = 1'b1;
      tick();
      checks++; if ({mc_valid, mc_type, mc_size, mc_addr} !== {1'b1, 1'b0, 3'd1, 32'h20}) begin
         errors++; $display("FAIL prio_ls_first got=%0b/%0b/%0d/%h exp=1/0/1/00000020", mc_valid, mc_type, mc_size, mc_addr); end
      serve(3, 32'h1234_5678);
      ls_req = 1'b0;
      checks++; if ({ls_done, ls_rdata, if_done} !== {1'b1, 32'h0000_0078, 1'b0}) begin
         errors++; $display("FAIL prio_ls_done got=%0b/%h/%0b exp=1/00000078/0", ls_done, ls_rdata, if_done); end
      $display("txn load addr=00000020 data=%h", ls_rdata);
      tick();
      checks++; if ({mc_valid, mc_type, mc_size, mc_addr} !== {1'b1, 1'b0, 3'd4, 32'h1100}) begin
         errors++; $display("FAIL prio_if_next got=%0b/%0b/%0d/%h exp=1/0/4/00001100", mc_valid, mc_type, mc_size, mc_addr); end
      serve(2, 32'hA5A5_0001);
      if_req = 1'b0;
      checks++; if ({if_done, if_data} !== {1'b1, 32'hA5A5_0001}) begin
         errors++; $display("FAIL prio_if_done got=%0b/%h exp=1/a5a50001", if_done, if_data); end
      tick();
   endtask

   task automatic test_starve();
      int          cnt = 0;
      bit          exp_if;
      bit          pre_if;
      logic [31:0] exp_addr;
      if_addr = 32'h2000; if_req = 1'b1;
      ls_wr = 1'b0; ls_size = 3'd4; ls_addr = 32'h40; ls_req = 1'b1;
      for (int k = 0; k < 11; k++) begin
         pre_if = if_req;
         tick();
         exp_if = pre_if && (cnt == STARVE_MAX);
         if (exp_if) cnt = 0;
         else if (pre_if && cnt < STARVE_MAX) cnt++;
         exp_addr = exp_if ? if_addr : ls_addr;
         checks++; if ({mc_valid, mc_addr} !== {1'b1, exp_addr}) begin
            errors++; $display("FAIL starve_grant_%0d got=%0b/%h exp=1/%h", k, mc_valid, mc_addr, exp_addr); end
         serve(1, mem_word(exp_addr));
         checks++; if ({mc_valid, if_done, ls_done} !== {1'b0, exp_if, !exp_if}) begin
            errors++; $display("FAIL starve_done_%0d got=%0b/%0b/%0b exp=0/%0b/%0b", k, mc_valid, if_done, ls_done, exp_if, !exp_if); end
         $display("txn starve %0d %s addr=%h", k, exp_if ? "fetch" : "load", exp_addr);
         if (exp_if) if_req = 1'b0;
         if (k == 5) begin if_addr = 32'h2100; if_req = 1'b1; end
      end
      ls_req = 1'b0;
      tick();
   endtask

   task automatic test_jump();
      // Flushed fetch drains without a done pulse.
      if_addr = 32'h3000; if_req = 1'b1;
      tick();
      checks++; if ({mc_valid, mc_addr} !== {1'b1, 32'h3000}) begin
         errors++; $display("FAIL jump_fetch_grant got=%0b/%h exp=1/00003000", mc_valid, mc_addr); end
      tick();
      jump_rst = 1'b1; if_req = 1'b0;
      tick();
      jump_rst = 1'b0;
      for (int i = 0; i < 2; i++) begin
         checks++; if ({mc_valid, mc_addr} !== {1'b1, 32'h3000}) begin
            errors++; $display("FAIL jump_drain_hold got=%0b/%h exp=1/00003000", mc_valid, mc_addr); end
         tick();
      end
      serve(0, 32'hAAAA_AAAA);
      checks++; if ({if_done, mc_valid} !== 2'b00) begin
         errors++; $display("FAIL jump_drain_done got=%0b/%0b exp=0/0", if_done, mc_valid); end
      tick();
      checks++; if ({if_done, mc_valid} !== 2'b00) begin
         errors++; $display("FAIL jump_drain_after got=%0b/%0b exp=0/0", if_done, mc_valid); end

      // Store survives a flush.
      ls_wr = 1'b1; ls_addr = 32'h30; ls_size = 3'd2; ls_wdata = 32'hCAFE_BABE; ls_req = 1'b1;
      tick();
      checks++; if ({mc_valid, mc_type, mc_size, mc_addr, mc_wdata} !== {1'b1, 1'b1, 3'd2, 32'h30, 32'hCAFE_BABE}) begin
         errors++; $display("FAIL jump_store_grant got=%0b/%0b/%0d/%h/%h", mc_valid, mc_type, mc_size, mc_addr, mc_wdata); end
      jump_rst = 1'b1;
      tick();
      jump_rst = 1'b0;
      checks++; if (mc_valid !== 1'b1) begin errors++; $display("FAIL jump_store_hold got=%0b exp=1", mc_valid); end
      serve(1, 32'hFFFF_FFFF);
      ls_req = 1'b0;
      checks++; if ({ls_done, ls_rdata} !== {1'b1, 32'h0}) begin
         errors++; $display("FAIL jump_store_done got=%0b/%h exp=1/00000000", ls_done, ls_rdata); end
      $display("txn store addr=00000030 flushed-but-committed");
      tick();

      // Flush coincident with completion of a load suppresses ls_done.
      ls_wr = 1'b0; ls_addr = 32'h50; ls_size = 3'd4; ls_req = 1'b1;
      tick();
      tick();
      jump_rst = 1'b1; mc_done = 1'b1; mc_rdata = 32'h1357_9BDF; ls_req = 1'b0;
      tick();
      jump_rst = 1'b0; mc_done = 1'b0;
      checks++; if ({ls_done, mc_valid} !== 2'b00) begin
         errors++; $display("FAIL jump_coincident got=%0b/%0b exp=0/0", ls_done, mc_valid); end

      // Flush in IDLE blocks the grant and clears the starvation count.
      if_addr = 32'h3100; if_req = 1'b1;
      ls_wr = 1'b0; ls_addr = 32'h60; ls_size = 3'd1; ls_req = 1'b1;
      for (int k = 0; k < STARVE_MAX; k++) begin
         tick();
         checks++; if ({mc_valid, mc_addr} !== {1'b1, 32'h60}) begin
            errors++; $display("FAIL jump_pre_ls_%0d got=%0b/%h exp=1/00000060", k, mc_valid, mc_addr); end
         serve(0, mem_word(32'h60));
      end
      jump_rst = 1'b1;
      tick();
      jump_rst = 1'b0;
      checks++; if (mc_valid !== 1'b0) begin errors++; $display("FAIL jump_idle_nogrant got=%0b exp=0", mc_valid); end
      tick();
      checks++; if ({mc_valid, mc_addr} !== {1'b1, 32'h60}) begin
         errors++; $display("FAIL jump_idle_cleared got=%0b/%h exp=1/00000060", mc_valid, mc_addr); end
      serve(0, mem_word(32'h60));
      ls_req = 1'b0;
      checks++; if ({ls_done, ls_rdata} !== {1'b1, load_expect(mem_word(32'h60), 3'd1)}) begin
         errors++; $display("FAIL jump_idle_load got=%0b/%h", ls_done, ls_rdata); end
      tick();
      checks++; if ({mc_valid, mc_addr} !== {1'b1, 32'h3100}) begin
         errors++; $display("FAIL jump_idle_if got=%0b/%h exp=1/00003100", mc_valid, mc_addr); end
      serve(0, 32'h0);
      if_req = 1'b0;
      tick();
   endtask

   task automatic test_rdy();
      if_addr = 32'h4000; if_req = 1'b1;
      tick();
      tick();
      rdy = 1'b0; mc_done = 1'b1; mc_rdata = 32'h1111_2222;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if ({mc_valid, if_done} !== 2'b10) begin
            errors++; $display("FAIL rdy_freeze_%0d got=%0b/%0b exp=1/0", i, mc_valid, if_done); end
      end
      rdy = 1'b1;
      tick();
      mc_done = 1'b0;
      checks++; if ({if_done, if_data, mc_valid} !== {1'b1, 32'h1111_2222, 1'b0}) begin
         errors++; $display("FAIL rdy_resume got=%0b/%h/%0b exp=1/11112222/0", if_done, if_data, mc_valid); end
      rdy = 1'b0; if_req = 1'b0;
      ls_wr = 1'b0; ls_addr = 32'h70; ls_size = 3'd2; ls_req = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++; if ({if_done, mc_valid} !== 2'b10) begin
            errors++; $display("FAIL rdy_hold_pulse_%0d got=%0b/%0b exp=1/0", i, if_done, mc_valid); end
      end
      rdy = 1'b1;
      tick();
      checks++; if ({if_done, mc_valid, mc_addr} !== {1'b0, 1'b1, 32'h70}) begin
         errors++; $display("FAIL rdy_regrant got=%0b/%0b/%h exp=0/1/00000070", if_done, mc_valid, mc_addr); end
      serve(1, 32'h8765_4321);
      ls_req = 1'b0;
      checks++; if ({ls_done, ls_rdata} !== {1'b1, 32'h0000_4321}) begin
         errors++; $display("FAIL rdy_load got=%0b/%h exp=1/00004321", ls_done, ls_rdata); end
      tick();
   endtask

   task automatic test_rst_mid();
      logic [134:0] outs;
      ls_wr = 1'b0; ls_addr = 32'h80; ls_size = 3'd4; ls_req = 1'b1;
      tick();
      checks++; if (mc_valid !== 1'b1) begin errors++; $display("FAIL rstmid_grant got=%0b exp=1", mc_valid); end
      tick();
      #2;
      rst = 1'b0;
      #1;
      outs = {mc_valid, mc_type, mc_addr, mc_size, mc_wdata, if_done, ls_done, if_data, ls_rdata};
      checks++; if (outs !== '0) begin errors++; $display("FAIL rstmid_async got=%h exp=0", outs); end
      ls_req = 1'b0;
      tick(); tick();
      rst = 1'b1; mc_done = 1'b1; mc_rdata = 32'hFFFF_FFFF;
      tick();
      mc_done = 1'b0;
      for (int i = 0; i < 2; i++) begin
         checks++; if ({ls_done, mc_valid} !== 2'b00) begin
            errors++; $display("FAIL rstmid_no_done got=%0b/%0b exp=0/0", ls_done, mc_valid); end
         tick();
      end
      rst = 1'b0; if_addr = 32'h5000; if_req = 1'b1;
      tick();
      rst = 1'b1;
      tick();
      checks++; if ({mc_valid, mc_addr} !== {1'b1, 32'h5000}) begin
         errors++; $display("FAIL rstmid_first_grant got=%0b/%h exp=1/00005000", mc_valid, mc_addr); end
      serve(0, 32'h0);
      if_req = 1'b0;
      tick();
   endtask

   task automatic test_random();
      bit          busy = 1'b0;
      bit          cur_if = 1'b0;
      bit          cur_wr = 1'b0;
      logic [31:0] cur_addr = '0;
      logic [31:0] cur_wdata = '0;
      logic [2:0]  cur_size = '0;
      int          lat = 0;
      int          cnt = 0;
      int          grants = 0;
      bit          pre_if, pre_ls, pre_done;
      bit          exp_if_done, exp_ls_done;
      logic [31:0] exp_data;
      for (int cyc = 0; cyc < 1500; cyc++) begin
         pre_if = if_req; pre_ls = ls_req; pre_done = mc_done;
         tick();
         mc_done = 1'b0;
         exp_if_done = 1'b0; exp_ls_done = 1'b0;
         if (busy && pre_done) begin
            busy = 1'b0;
            if (cur_if) begin exp_if_done = 1'b1; if_req = 1'b0; end
            else begin exp_ls_done = 1'b1; ls_req = 1'b0; end
         end else if (!busy && (pre_if || pre_ls)) begin
            busy = 1'b1;
            grants++;
            if (pre_if && (!pre_ls || cnt == STARVE_MAX)) begin
               cur_if = 1'b1; cnt = 0; cur_wr = 1'b0;
               cur_addr = if_addr; cur_size = 3'd4;
            end else begin
               cur_if = 1'b0;
               if (pre_if && cnt < STARVE_MAX) cnt++;
               cur_wr = ls_wr; cur_addr = ls_addr;
               cur_size = fwd_size(ls_size); cur_wdata = ls_wdata;
            end
            lat = $urandom_range(0, 5);
         end
         checks++; if (mc_valid !== busy) begin
            errors++; $display("FAIL rnd_valid cyc=%0d got=%0b exp=%0b", cyc, mc_valid, busy); end
         if (busy) begin
            checks++; if ({mc_type, mc_addr, mc_size} !== {cur_wr, cur_addr, cur_size}) begin
               errors++; $display("FAIL rnd_fields cyc=%0d got=%0b/%h/%0d exp=%0b/%h/%0d", cyc, mc_type, mc_addr, mc_size, cur_wr, cur_addr, cur_size); end
            if (cur_wr) begin
               checks++; if (mc_wdata !== cur_wdata) begin
                  errors++; $display("FAIL rnd_wdata cyc=%0d got=%h exp=%h", cyc, mc_wdata, cur_wdata); end
            end
         end
         checks++; if ({if_done, ls_done} !== {exp_if_done, exp_ls_done}) begin
            errors++; $display("FAIL rnd_done cyc=%0d got=%0b/%0b exp=%0b/%0b", cyc, if_done, ls_done, exp_if_done, exp_ls_done); end
         if (exp_if_done) begin
            exp_data = mem_word(cur_addr);
            checks++; if (if_data !== exp_data) begin
               errors++; $display("FAIL rnd_if_data cyc=%0d got=%h exp=%h", cyc, if_data, exp_data); end
            $display("txn rnd fetch addr=%h data=%h", cur_addr, exp_data);
         end
         if (exp_ls_done) begin
            exp_data = cur_wr ? 32'h0 : load_expect(mem_word(cur_addr), cur_size);
            checks++; if (ls_rdata !== exp_data) begin
               errors++; $display("FAIL rnd_ls_data cyc=%0d got=%h exp=%h", cyc, ls_rdata, exp_data); end
            $display("txn rnd %s addr=%h size=%0d data=%h", cur_wr ? "store" : "load", cur_addr, cur_size, exp_data);
         end
         // Controller side.
         if (busy) begin
            if (lat == 0) begin mc_done = 1'b1; mc_rdata = mem_word(cur_addr); end
            else lat--;
         end
         // Requester side: new requests only while the run is still active.
         if (cyc < 1400) begin
            if (!if_req && $urandom_range(0, 3) == 0) begin
               if_addr = $urandom; if_req = 1'b1;
            end
            if (!ls_req && $urandom_range(0, 2) == 0) begin
               ls_wr    = 1'($urandom_range(0, 1));
               ls_addr  = $urandom;
               ls_wdata = $urandom;
               if (ls_wr) ls_size = 3'($urandom_range(0, 7));
               else ls_size = 3'd1 << $urandom_range(0, 2);
               ls_req = 1'b1;
            end
         end
      end
      checks++; if (grants < 100 || busy || mc_valid !== 1'b0) begin
         errors++; $display("FAIL rnd_progress grants=%0d busy=%0b mc_valid=%0b exp>=100/0/0", grants, busy, mc_valid); end
   endtask

   initial begin
      rst = 1'b0; rdy = 1'b1; jump_rst = 1'b0;
      if_req = 1'b0; if_addr = '0;
      ls_req = 1'b0; ls_wr = 1'b0; ls_addr = '0; ls_size = '0; ls_wdata = '0;
      mc_done = 1'b0; mc_rdata = '0;
      test_reset();
      test_fetch();
      test_priority();
      test_starve();
      test_jump();
      test_rdy();
      test_rst_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 4, meaning: max consecutive load/store grants issued while if_req is pending before IF is forced.
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-low (0 = reset).
REQ-004 rdy  input  1  global enable; 0 freezes all state and registered outputs.
REQ-005 jump_rst  input  1  pipeline flush (branch mispredict).
REQ-006 if_req  input  1  fetch request; held by requester until if_done.
REQ-007 if_addr  input  32  fetch byte address.
REQ-008 if_done  output  1  one-cycle pulse, fetch complete.
REQ-009 if_data  output  32  fetched word, valid while if_done=1.
REQ-010 ls_req  input  1  load/store request; held until ls_done.
REQ-011 ls_wr  input  1  1 = store, 0 = load.
REQ-012 ls_addr  input  32  load/store byte address.
REQ-013 ls_size  input  3  access bytes: 1, 2 or 4.
REQ-014 ls_wdata  input  32  store data, little-endian, low bytes used.
REQ-015 ls_done  output  1  one-cycle pulse, load/store complete.
REQ-016 ls_rdata  output  32  load data, valid while ls_done=1.
REQ-017 mc_valid  output  1  request to byte-serial memory controller; held until mc_done.
REQ-018 mc_type  output  1  1 = store, 0 = load/fetch.
REQ-019 mc_addr  output  32  forwarded address.
REQ-020 mc_size  output  3  forwarded size (4 for fetch).
REQ-021 mc_wdata  output  32  forwarded store data.
REQ-022 mc_done  input  1  one-cycle pulse from controller, transfer finished.
REQ-023 mc_rdata  input  32  controller read data, valid with mc_done.

Function
REQ-024 FSM states IDLE, BUSY_IF, BUSY_LS, DRAIN; one transaction outstanding at most.
REQ-025 IDLE, rdy=1, no jump_rst: grant IF if if_req and (!ls_req or starve_cnt==STARVE_MAX); else grant LS if ls_req; else stay IDLE.
REQ-026 Grant at edge N: mc_valid=1 and mc_type/addr/size/wdata registered at edge N, state BUSY_IF or BUSY_LS.
REQ-027 mc_* fields stay constant while mc_valid=1.
REQ-028 starve_cnt (width fits STARVE_MAX): +1 on each LS grant while if_req=1, saturating at STARVE_MAX; cleared on IF grant.
REQ-029 ls_size not in {1,2,4}: mc_size forced to 4.
REQ-030 BUSY_x with mc_done=1: mc_valid<=0, state<=IDLE, matching done<=1 for exactly one cycle, data registered same edge.
REQ-031 Load data: ls_rdata = mc_rdata with bytes at and above ls_size zeroed (size 1 -> [31:8]=0, size 2 -> [31:16]=0); store ls_rdata=0.
REQ-032 No new grant in the cycle done pulses; earliest re-grant is the edge after the done edge (2-cycle minimum gap between grants).
REQ-033 jump_rst in IDLE: no grant that cycle; starve_cnt cleared.
REQ-034 jump_rst in BUSY_IF, or BUSY_LS with mc_type=0: state<=DRAIN, mc_valid held until mc_done, no done pulse issued.
REQ-035 jump_rst in BUSY_LS with mc_type=1 (store): store continues, ls_done still pulses (committed store never dropped).
REQ-036 DRAIN with mc_done: mc_valid<=0, state<=IDLE, data discarded.
REQ-037 jump_rst coincident with mc_done in BUSY_IF or load: go to IDLE, suppress done.
REQ-038 rdy=0: FSM, counters, done pulses and all outputs hold; mc_done is not sampled while rdy=0.

Reset
REQ-039 rst=0 asynchronously: state=IDLE, starve_cnt=0, mc_valid=0, mc_type=0, mc_addr=0, mc_size=0, mc_wdata=0, if_done=0, ls_done=0, if_data=0, ls_rdata=0.
REQ-040 rst=0 mid-transaction abandons it, no done pulse; first grant possible at first rising edge with rst=1.

Verification
REQ-041 if_req, if_addr=0x1000 alone; mc_done 5 cycles later with mc_rdata=0xDEADBEEF -> mc_addr=0x1000, mc_size=4, if_done one cycle, if_data=0xDEADBEEF.
REQ-042 if_req and ls_req (load, size 1, 0x20) held, mc_rdata=0x12345678 -> LS granted first, ls_rdata=0x00000078; IF granted next.
REQ-043 ls_req held continuously with if_req, STARVE_MAX=4 -> exactly 4 LS grants then an IF grant, starve_cnt back to 0.
REQ-044 jump_rst during in-flight fetch -> DRAIN, mc_valid held until mc_done, no if_done; jump_rst during store 0x30 size 2 -> ls_done still pulses.
REQ-045 rdy=0 for 3 cycles while mc_done pulses -> no state change or done pulse until rdy=1 and mc_done sampled.
REQ-046 rst=0 asserted mid-BUSY_LS -> all outputs zero immediately, no ls_done afterwards.
